// File: rtl/kvdecompressor_core.sv
// KV-cache INT8 -> INT16 dequantizer with an OBI master port.
// Define KVDECOMP_ROUND_EN for round-half-up instead of floor.
module kvdecompressor_core #(
  parameter int unsigned VECTOR_MAX_LEN = 512,
  parameter int unsigned FRAC_BITS      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] scale_i,
  input  logic [7:0]  zp_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [31:0] length_i,
  input  logic        int_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        irq_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int LW = $clog2(VECTOR_MAX_LEN + 1);
  localparam int YW = 26 - FRAC_BITS;

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_WAIT,
    WRITE_REQ,
    WRITE_WAIT,
    FINISH
  } state_t;

  state_t        state;
  logic [15:0]   scale_q;
  logic [7:0]    zp_q;
  logic [31:0]   src_q;
  logic [31:0]   dst_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt;
  logic [31:0]   src_off;
  logic [31:0]   dst_off;
  logic [15:0]   hi_q;
  logic          half;

  logic [LW-1:0] len_c;
  logic [LW-1:0] cnt_n;
  logic [LW:0]   cnt_sum;

  assign mem_be_o = 4'hF;

  always_comb begin
    len_c = length_i[LW-1:0];
    if (length_i > 32'(VECTOR_MAX_LEN)) begin
      len_c = LW'(VECTOR_MAX_LEN);
    end
    cnt_sum = {1'b0, cnt} + (LW+1)'(2);
    cnt_n   = cnt_sum[LW-1:0];
    if (cnt_sum >= {1'b0, len_q}) begin
      cnt_n = len_q;
    end
  end

  function automatic logic [15:0] deq(input logic [7:0] q);
    logic signed [8:0]    d;
    logic signed [25:0]   dx;
    logic signed [25:0]   sx;
    logic signed [25:0]   p;
    logic signed [YW-1:0] y;
    logic [15:0]          r;
    d  = $signed({q[7], q}) - $signed({zp_q[7], zp_q});
    dx = 26'(d);
    sx = 26'($signed({1'b0, scale_q}));
    p  = dx * sx;
`ifdef KVDECOMP_ROUND_EN
    p  = p + (26'sd1 <<< (FRAC_BITS - 1));
`endif
    y  = p[25:FRAC_BITS];
    r  = y[15:0];
    if (y[YW-1] && !(&y[YW-1:15])) begin
      r = 16'h8000;
    end else if (!y[YW-1] && (|y[YW-1:15])) begin
      r = 16'h7FFF;
    end
    return r;
  endfunction

  // elements at or past the length pack as zero
  function automatic logic [31:0] pack(
    input logic [15:0]   b,
    input logic [LW-1:0] base
  );
    logic [LW:0] i0;
    logic [LW:0] i1;
    logic [15:0] lo;
    logic [15:0] hi;
    i0 = {1'b0, base};
    i1 = i0 + (LW+1)'(1);
    lo = (i0 < {1'b0, len_q}) ? deq(b[7:0])  : 16'h0;
    hi = (i1 < {1'b0, len_q}) ? deq(b[15:8]) : 16'h0;
    return {hi, lo};
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      scale_q     <= '0;
      zp_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cnt         <= '0;
      src_off     <= '0;
      dst_off     <= '0;
      hi_q        <= '0;
      half        <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      irq_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
    end else begin
      irq_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            scale_q <= scale_i;
            zp_q    <= zp_i;
            src_q   <= src_addr_i;
            dst_q   <= dst_addr_i;
            len_q   <= len_c;
            cnt     <= '0;
            src_off <= '0;
            dst_off <= '0;
            half    <= 1'b0;
            err_o   <= 1'b0;
            if (len_c == '0) begin
              state  <= FINISH;
              done_o <= 1'b1;
              irq_o  <= int_en_i;
            end else begin
              state      <= READ_REQ;
              busy_o     <= 1'b1;
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= src_addr_i;
            end
          end
        end
        READ_REQ: begin
          if (mem_gnt_i) begin
            state     <= READ_WAIT;
            mem_req_o <= 1'b0;
          end
        end
        READ_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              state    <= FINISH;
              err_o    <= 1'b1;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              irq_o    <= int_en_i;
              mem_we_o <= 1'b0;
            end else begin
              hi_q        <= mem_rdata_i[31:16];
              src_off     <= src_off + 32'd4;
              half        <= 1'b0;
              state       <= WRITE_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= dst_q + dst_off;
              mem_wdata_o <= pack(mem_rdata_i[15:0], cnt);
            end
          end
        end
        WRITE_REQ: begin
          if (mem_gnt_i) begin
            state     <= WRITE_WAIT;
            mem_req_o <= 1'b0;
          end
        end
        WRITE_WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              state    <= FINISH;
              err_o    <= 1'b1;
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              irq_o    <= int_en_i;
              mem_we_o <= 1'b0;
            end else begin
              dst_off <= dst_off + 32'd4;
              cnt     <= cnt_n;
              if (cnt_n >= len_q) begin
                state    <= FINISH;
                busy_o   <= 1'b0;
                done_o   <= 1'b1;
                irq_o    <= int_en_i;
                mem_we_o <= 1'b0;
              end else if (!half) begin
                half        <= 1'b1;
                state       <= WRITE_REQ;
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_addr_o  <= dst_q + dst_off + 32'd4;
                mem_wdata_o <= pack(hi_q, cnt_n);
              end else begin
                state      <= READ_REQ;
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= src_q + src_off;
              end
            end
          end
        end
        FINISH: begin
          if (!start_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kvdecompressor_core.sv
// Self-checking bench for kvdecompressor_core.
// Reference model dequantizes with integer arithmetic and a bus responder.
module tb_kvdecompressor_core;

  localparam logic [31:0] SRC = 32'h0000_1000;
  localparam logic [31:0] DST = 32'h0002_0000;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] scale_i;
  logic [7:0]  zp_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [31:0] length_i;
  logic        int_en_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        irq_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  always #5 clk = ~clk;

  kvdecompressor_core dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .scale_i      (scale_i),
    .zp_i         (zp_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .length_i     (length_i),
    .int_en_i     (int_en_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .irq_o        (irq_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  int nchk = 0;
  int nfail = 0;

  logic [31:0] src_words [0:127];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int          nreads;
  int          irq_cnt;
  int          stab_errs;
  int          req_cycles;
  int          gnt_delay;
  bit          err_read;
  int          wait_cnt;
  bit          rsp_pend;
  logic [31:0] rsp_data;
  bit          rsp_err;
  bit          held;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_we;
  logic [31:0] idx;

  // bus slave: grant after gnt_delay cycles, respond the cycle after
  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    if (!rst_ni) begin
      rsp_pend = 0;
      held     = 0;
      wait_cnt = 0;
    end else begin
      if (irq_o) irq_cnt++;
      if (rsp_pend) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rsp_data;
        mem_err_i    = rsp_err;
        rsp_pend     = 0;
      end else if (mem_req_o) begin
        req_cycles++;
        if (held && (mem_addr_o !== h_addr || mem_we_o !== h_we ||
                     (mem_we_o && mem_wdata_o !== h_wdata)))
          stab_errs++;
        if (!held) begin
          held    = 1;
          h_addr  = mem_addr_o;
          h_we    = mem_we_o;
          h_wdata = mem_wdata_o;
        end
        if (wait_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          held      = 0;
          wait_cnt  = 0;
          rsp_pend  = 1;
          rsp_err   = 0;
          if (mem_we_o) begin
            wa_q.push_back(mem_addr_o);
            wd_q.push_back(mem_wdata_o);
            rsp_data = 32'h0;
          end else begin
            nreads++;
            idx      = (mem_addr_o - SRC) >> 2;
            rsp_data = src_words[idx[6:0]];
            rsp_err  = err_read;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_elem(input int i, input int lc,
                                           input logic [15:0] sc,
                                           input logic [7:0] z);
    logic [31:0] w;
    logic [7:0]  b;
    int          q;
    int          zz;
    longint      p;
    longint      y;
    logic [63:0] yv;
    if (i >= lc) return 16'h0;
    w  = src_words[i / 4];
    b  = w[8 * (i % 4) +: 8];
    q  = $signed(b);
    zz = $signed(z);
    p  = longint'(q - zz) * longint'({16'h0, sc});
`ifdef KVDECOMP_ROUND_EN
    p  = p + 128;
`endif
    y  = p >>> 8;
    if (y > 32767) return 16'h7FFF;
    if (y < -32768) return 16'h8000;
    yv = y;
    return yv[15:0];
  endfunction

  task automatic run_job(input logic [15:0] sc, input logic [7:0] z,
                         input int len, input int gd, input bit ie,
                         input bit rerr);
    int lc;
    int to;
    int nw;
    logic [31:0] e_err;
    logic [31:0] e_done;
    logic [31:0] ed;
    lc = (len > 512) ? 512 : len;
    nw = rerr ? 0 : (lc + 1) / 2;
    scale_i    = sc;
    zp_i       = z;
    length_i   = len;
    int_en_i   = ie;
    src_addr_i = SRC;
    dst_addr_i = DST;
    gnt_delay  = gd;
    err_read   = rerr;
    wa_q.delete();
    wd_q.delete();
    nreads    = 0;
    irq_cnt   = 0;
    stab_errs = 0;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    scale_i  = ~sc;
    length_i = 32'd2;
    to = 0;
    while (!done_o && to < LIMIT) begin
      @(negedge clk);
      to++;
    end
    check("done_timeout", 32'(to < LIMIT), 32'd1);
    e_err  = 32'(err_o);
    e_done = 32'(done_o);
    check("done", e_done, 32'd1);
    check("err", e_err, 32'(rerr));
    @(negedge clk);
    @(negedge clk);
    check("irq_cycles", irq_cnt, 32'(ie));
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_done", 32'(done_o), 32'd0);
    check("reads", nreads, rerr ? 32'd1 : 32'((lc + 3) / 4));
    check("req_stable", stab_errs, 32'd0);
    check("nwrites", wa_q.size(), nw);
    if (wa_q.size() == nw) begin
      for (int j = 0; j < nw; j++) begin
        ed = {ref_elem(2 * j + 1, lc, sc, z), ref_elem(2 * j, lc, sc, z)};
        check("waddr", wa_q[j], DST + 32'(4 * j));
        check("wdata", wd_q[j], ed);
      end
    end
  endtask

  initial begin
    int to;
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    scale_i    = '0;
    zp_i       = '0;
    src_addr_i = '0;
    dst_addr_i = '0;
    length_i   = '0;
    int_en_i   = 1'b0;
    gnt_delay  = 0;
    err_read   = 0;
    req_cycles = 0;
    irq_cnt    = 0;
    for (int i = 0; i < 128; i++) src_words[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_be", 32'(mem_be_o), 32'hF);
    rst_ni = 1'b1;
    @(negedge clk);

    src_words[0] = 32'h80FF017F;
    run_job(16'h0100, 8'h00, 4, 0, 1'b1, 1'b0);
    if (wd_q.size() == 2) begin
      check("basic_w0", wd_q[0], 32'h0001007F);
      check("basic_w1", wd_q[1], 32'hFF80FFFF);
    end

    src_words[0] = 32'h0000007F;
    run_job(16'hFFFF, 8'h80, 1, 0, 1'b0, 1'b0);
    if (wd_q.size() == 1) check("sat_pos", wd_q[0], 32'h00007FFF);
    src_words[0] = 32'h00000080;
    run_job(16'hFFFF, 8'h7F, 1, 1, 1'b0, 1'b0);
    if (wd_q.size() == 1) check("sat_neg", wd_q[0], 32'h00008000);

    src_words[0] = 32'h04030201;
    run_job(16'h0100, 8'h00, 3, 0, 1'b1, 1'b0);
    if (wd_q.size() == 2) begin
      check("odd_w0", wd_q[0], 32'h00020001);
      check("odd_w1", wd_q[1], 32'h00000003);
    end

    // empty run holds start so FINISH is observable
    req_cycles = 0;
    irq_cnt    = 0;
    length_i   = 32'd0;
    int_en_i   = 1'b1;
    start_i    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("len0_done", 32'(done_o), 32'd1);
    check("len0_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("len0_noreq", req_cycles, 32'd0);
    check("len0_irq", irq_cnt, 32'd1);
    check("len0_idle", 32'(done_o), 32'd0);

    for (int i = 0; i < 8; i++) src_words[i] = $urandom;
    run_job(16'(($urandom)), 8'(($urandom)), 10, 3, 1'b0, 1'b0);
    run_job(16'h0100, 8'h00, 8, 0, 1'b1, 1'b1);

    src_words[0] = 32'h0000FD03;
    run_job(16'h0080, 8'h00, 2, 0, 1'b0, 1'b0);
`ifdef KVDECOMP_ROUND_EN
    if (wd_q.size() == 1) check("round", wd_q[0], 32'hFFFF0002);
`else
    if (wd_q.size() == 1) check("floor", wd_q[0], 32'hFFFE0001);
`endif

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) src_words[i] = $urandom;
      run_job(16'(($urandom)), 8'(($urandom)), $urandom_range(1, 40),
              $urandom_range(0, 2), 1'($urandom), 1'b0);
    end

    for (int i = 0; i < 128; i++) src_words[i] = $urandom;
    run_job(16'h0180, 8'h05, 1000, 0, 1'b1, 1'b0);

    // abandon a run while a write response is outstanding
    wa_q.delete();
    wd_q.delete();
    scale_i    = 16'h0100;
    zp_i       = 8'h00;
    length_i   = 32'd16;
    src_addr_i = SRC;
    dst_addr_i = DST;
    gnt_delay  = 0;
    start_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    to = 0;
    while (wa_q.size() < 1 && to < 200) begin
      @(posedge clk);
      #1;
      to++;
    end
    check("mid_reach_write", 32'(to < 200), 32'd1);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", 32'(busy_o), 32'd0);
    check("mid_req", 32'(mem_req_o), 32'd0);
    check("mid_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) src_words[i] = $urandom;
    run_job(16'h0200, 8'hF0, 7, 1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
